// File: rtl/hub_pkg.sv
// Shared hub definitions: parser state encoding and MAC geometry.
package hub_pkg;

  localparam int unsigned DA_BYTES = 6;
  localparam int unsigned MAC_W    = 48;

  typedef enum logic [2:0] {
    IDLE,
    DST,
    SKIP,
    PAY,
    DROP
  } rx_state_t;

endpackage

// File: rtl/hub_rx_stats.sv
// Saturating frame/byte statistics for one hub ingress port.
module hub_rx_stats (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_ok_i,
  input  logic        frame_err_i,
  input  logic        byte_i,
  output logic [15:0] frames_ok_o,
  output logic [15:0] frames_err_o,
  output logic [31:0] bytes_o
);

  logic [15:0] ok_q, ok_d;
  logic [15:0] err_q, err_d;
  logic [31:0] bytes_q, bytes_d;

  always_comb begin
    ok_d    = ok_q;
    err_d   = err_q;
    bytes_d = bytes_q;
    if (frame_ok_i && (ok_q != '1))     ok_d    = ok_q + 16'd1;
    if (frame_err_i && (err_q != '1))   err_d   = err_q + 16'd1;
    if (byte_i && (bytes_q != '1))      bytes_d = bytes_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ok_q    <= '0;
      err_q   <= '0;
      bytes_q <= '0;
    end else begin
      ok_q    <= ok_d;
      err_q   <= err_d;
      bytes_q <= bytes_d;
    end
  end

  assign frames_ok_o  = ok_q;
  assign frames_err_o = err_q;
  assign bytes_o      = bytes_q;

endmodule

// File: rtl/hub_rx_frame_parser.sv
// Per-port ingress parser: SOF/EOF byte stream -> dest MAC + payload stream.
// Define HUB_RX_STATS_EN to add saturating frame/byte statistics outputs.
module hub_rx_frame_parser
  import hub_pkg::*;
#(
  parameter int unsigned HDR_SKIP_BYTES = 8,
  parameter int unsigned MAX_PAYLOAD    = 1500,
  parameter int unsigned LEN_W          = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  input  logic             rx_sof,
  input  logic             rx_eof,
  output logic [MAC_W-1:0] dest_mac,
  output logic [7:0]       payload,
  output logic             tx_valid,
  output logic             tx_last,
  output logic [LEN_W-1:0] payload_len,
  output logic             frame_done,
  output logic             err_pulse
`ifdef HUB_RX_STATS_EN
  ,
  output logic [15:0]      stat_frames_ok,
  output logic [15:0]      stat_frames_err,
  output logic [31:0]      stat_bytes
`endif
);

  localparam int unsigned      DA_W      = MAC_W - 8;
  localparam logic [LEN_W-1:0] DA_LAST   = LEN_W'(DA_BYTES - 2);
  localparam logic [LEN_W-1:0] SKIP_LAST = LEN_W'(HDR_SKIP_BYTES - 1);
  localparam logic [LEN_W-1:0] MAX_LEN   = LEN_W'(MAX_PAYLOAD);

  rx_state_t        state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [DA_W-1:0]  da_q, da_d;
  logic [MAC_W-1:0] dest_mac_q, dest_mac_d;
  logic [7:0]       payload_q, payload_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             tx_valid_q, tx_valid_d;
  logic             tx_last_q, tx_last_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    da_d       = da_q;
    dest_mac_d = dest_mac_q;
    payload_d  = payload_q;
    len_d      = len_q;
    tx_valid_d = 1'b0;
    tx_last_d  = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;

    if (rx_valid) begin
      if (rx_sof) begin
        // SOF always wins: it aborts any frame in flight and restarts as DA byte 0
        err_d   = rx_eof || (state_q != IDLE);
        cnt_d   = '0;
        da_d    = DA_W'(rx_data);
        state_d = rx_eof ? IDLE : DST;
      end else begin
        unique case (state_q)
          IDLE: ;
          DST: begin
            if (rx_eof) begin
              err_d   = 1'b1;
              cnt_d   = '0;
              state_d = IDLE;
            end else if (cnt_q == DA_LAST) begin
              dest_mac_d = {da_q, rx_data};
              cnt_d      = '0;
              state_d    = SKIP;
            end else begin
              da_d  = {da_q[DA_W-9:0], rx_data};
              cnt_d = cnt_inc;
            end
          end
          SKIP: begin
            if (rx_eof) begin
              err_d   = 1'b1;
              cnt_d   = '0;
              state_d = IDLE;
            end else if (cnt_q == SKIP_LAST) begin
              cnt_d   = '0;
              state_d = PAY;
            end else begin
              cnt_d = cnt_inc;
            end
          end
          PAY: begin
            // cnt holds bytes already forwarded; at MAX_LEN this byte is the overflow one
            if (cnt_q >= MAX_LEN) begin
              err_d   = 1'b1;
              cnt_d   = '0;
              state_d = rx_eof ? IDLE : DROP;
            end else begin
              tx_valid_d = 1'b1;
              payload_d  = rx_data;
              cnt_d      = cnt_inc;
              if (rx_eof) begin
                tx_last_d = 1'b1;
                done_d    = 1'b1;
                len_d     = cnt_inc;
                cnt_d     = '0;
                state_d   = IDLE;
              end
            end
          end
          DROP: begin
            if (rx_eof) begin
              cnt_d   = '0;
              state_d = IDLE;
            end
          end
          default: begin
            cnt_d   = '0;
            state_d = IDLE;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      da_q       <= '0;
      dest_mac_q <= '0;
      payload_q  <= '0;
      len_q      <= '0;
      tx_valid_q <= 1'b0;
      tx_last_q  <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      da_q       <= da_d;
      dest_mac_q <= dest_mac_d;
      payload_q  <= payload_d;
      len_q      <= len_d;
      tx_valid_q <= tx_valid_d;
      tx_last_q  <= tx_last_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign dest_mac    = dest_mac_q;
  assign payload     = payload_q;
  assign tx_valid    = tx_valid_q;
  assign tx_last     = tx_last_q;
  assign payload_len = len_q;
  assign frame_done  = done_q;
  assign err_pulse   = err_q;

`ifdef HUB_RX_STATS_EN
  hub_rx_stats u_stats (
    .clk          (clk),
    .reset        (reset),
    .frame_ok_i   (done_q),
    .frame_err_i  (err_q),
    .byte_i       (tx_valid_q),
    .frames_ok_o  (stat_frames_ok),
    .frames_err_o (stat_frames_err),
    .bytes_o      (stat_bytes)
  );
`endif

endmodule
